// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: two-port (CPU, DMA) arbiter onto one single-ported memory.
// CPU normally wins; DMA wins once it has been refused STARVE_MAX cycles in a row.
// Read data returns one cycle after the grant through the port that issued it.
module mem_port_arbiter #(
    parameter int unsigned STARVE_MAX = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       c_req,
    input  logic       c_we,
    input  logic [7:0] c_addr,
    input  logic [7:0] c_wdata,
    output logic       c_gnt,
    output logic       c_rvalid,
    output logic [7:0] c_rdata,
    input  logic       d_req,
    input  logic       d_we,
    input  logic [7:0] d_addr,
    input  logic [7:0] d_wdata,
    output logic       d_gnt,
    output logic       d_rvalid,
    output logic [7:0] d_rdata,
    output logic       m_en,
    output logic       m_we,
    output logic [7:0] m_addr,
    output logic [7:0] m_wdata,
    input  logic [7:0] m_rdata,
    output logic       starving
);

    localparam int unsigned CNT_W = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RD_CPU = 2'd1,
        RD_DMA = 2'd2
    } ownerState_t;

    ownerState_t       state;
    logic [CNT_W-1:0]  starveCnt;
    logic [7:0]        cHold;
    logic [7:0]        dHold;
    logic              cWins;

    // Arbitration: CPU first unless the DMA starvation override is active.
    always_comb begin
        starving = (starveCnt == CNT_W'(STARVE_MAX));
        cWins    = c_req && !(starving && d_req);
        c_gnt    = !reset && cWins;
        d_gnt    = !reset && d_req && !cWins;
        m_en     = 1'b0;
        m_we     = 1'b0;
        m_addr   = 8'h00;
        m_wdata  = 8'h00;
        if (c_gnt) begin
            m_en    = 1'b1;
            m_we    = c_we;
            m_addr  = c_addr;
            m_wdata = c_wdata;
        end else if (d_gnt) begin
            m_en    = 1'b1;
            m_we    = d_we;
            m_addr  = d_addr;
            m_wdata = d_wdata;
        end
    end

    // Read return: the pending owner sees live memory data; otherwise hold the last value.
    // A read pending into a reset cycle is dropped.
    always_comb begin
        c_rvalid = (state == RD_CPU) && !reset;
        d_rvalid = (state == RD_DMA) && !reset;
        c_rdata  = c_rvalid ? m_rdata : cHold;
        d_rdata  = d_rvalid ? m_rdata : dHold;
    end

    // Owner FSM, starvation counter and read-data hold registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            starveCnt <= '0;
            cHold     <= 8'h00;
            dHold     <= 8'h00;
        end else begin
            if (c_gnt && !c_we) begin
                state <= RD_CPU;
            end else if (d_gnt && !d_we) begin
                state <= RD_DMA;
            end else begin
                state <= IDLE;
            end

            if (!d_req || d_gnt) begin
                starveCnt <= '0;
            end else if (starveCnt != CNT_W'(STARVE_MAX)) begin
                starveCnt <= starveCnt + CNT_W'(1);
            end

            if (state == RD_CPU) begin
                cHold <= m_rdata;
            end
            if (state == RD_DMA) begin
                dHold <= m_rdata;
            end
        end
    end

endmodule
